// File: rtl/eth_tx_arbiter_if.sv
// AXI-Stream bundle used by the Ethernet TX arbiter.
// The master modport drives a stream and the slave modport receives it.
interface eth_tx_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
);
   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic                  tvalid;
   logic                  tlast;
   logic                  tuser;
   logic                  tready;

   modport master (
      output tdata, tkeep, tvalid, tlast, tuser,
      input  tready
   );

   modport slave (
      input  tdata, tkeep, tvalid, tlast, tuser,
      output tready
   );
endinterface

// File: rtl/eth_tx_arbiter.sv
// Two-requester, frame-granular round-robin arbiter feeding a MAC TX stream.
// Optional per-port frame counters (frames0/frames1) are built when the macro
// ETH_TX_ARBITER_STATS_EN is defined; without it the ports are absent and the
// arbitration behaviour is unchanged.
module eth_tx_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
   input  logic                   clock,
   input  logic                   reset,
   eth_tx_arbiter_if.slave        s0_axis,
   eth_tx_arbiter_if.slave        s1_axis,
   eth_tx_arbiter_if.master       m_axis,
   output logic [1:0]             grant,
   output logic                   busy
`ifdef ETH_TX_ARBITER_STATS_EN
   ,
   output logic [31:0]            frames0,
   output logic [31:0]            frames1
`endif
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   logic [0:0]            state;
   logic                  sel;
   logic                  last;
   logic                  pick;
   logic                  any_valid;
   logic                  frame_done;

   logic [DATA_WIDTH-1:0] mux_tdata;
   logic [KEEP_WIDTH-1:0] mux_tkeep;
   logic                  mux_tvalid;
   logic                  mux_tlast;
   logic                  mux_tuser;

   // Choose the next owner: the lone requester, or the one not served last time.
   always_comb begin
      any_valid = s0_axis.tvalid | s1_axis.tvalid;
      if (s0_axis.tvalid && s1_axis.tvalid) begin
         pick = ~last;
      end else begin
         pick = s1_axis.tvalid;
      end
   end

   // A frame ends on the beat that carries tlast and is accepted downstream.
   assign frame_done = (state == GRANT) & mux_tvalid & m_axis.tready & mux_tlast;

   // Owner/pointer register and IDLE/GRANT sequencing; reset beats everything.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         sel   <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  state <= GRANT;
                  sel   <= pick;
                  last  <= pick;
               end
            end
            GRANT: begin
               if (frame_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Route the owner's stream to the MAC and its tready back; all zero when idle.
   always_comb begin
      mux_tdata      = '0;
      mux_tkeep      = '0;
      mux_tvalid     = 1'b0;
      mux_tlast      = 1'b0;
      mux_tuser      = 1'b0;
      s0_axis.tready = 1'b0;
      s1_axis.tready = 1'b0;
      if (state == GRANT) begin
         if (sel == 1'b0) begin
            mux_tdata      = s0_axis.tdata;
            mux_tkeep      = s0_axis.tkeep;
            mux_tvalid     = s0_axis.tvalid;
            mux_tlast      = s0_axis.tlast;
            mux_tuser      = s0_axis.tuser;
            s0_axis.tready = m_axis.tready;
         end else begin
            mux_tdata      = s1_axis.tdata;
            mux_tkeep      = s1_axis.tkeep;
            mux_tvalid     = s1_axis.tvalid;
            mux_tlast      = s1_axis.tlast;
            mux_tuser      = s1_axis.tuser;
            s1_axis.tready = m_axis.tready;
         end
      end
   end

   assign m_axis.tdata  = mux_tdata;
   assign m_axis.tkeep  = mux_tkeep;
   assign m_axis.tvalid = mux_tvalid;
   assign m_axis.tlast  = mux_tlast;
   assign m_axis.tuser  = mux_tuser;

   assign busy  = (state == GRANT);
   assign grant = (state == GRANT) ? (sel ? 2'b10 : 2'b01) : 2'b00;

`ifdef ETH_TX_ARBITER_STATS_EN
   // Count completed frames per owner; the counters wrap naturally at 2^32.
   always_ff @(posedge clock) begin
      if (reset) begin
         frames0 <= '0;
         frames1 <= '0;
      end else if (frame_done) begin
         if (sel) begin
            frames1 <= frames1 + 32'd1;
         end else begin
            frames0 <= frames0 + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Self-checking bench for eth_tx_arbiter: directed scenarios plus a randomized
// traffic run checked against a frame-level round-robin reference model.
// Define ETH_TX_ARBITER_STATS_EN to also exercise the frame counters.
module tb_eth_tx_arbiter;

   localparam int DATA_WIDTH = 8;
   localparam int KEEP_WIDTH = 1;

   typedef struct {
      logic [7:0] d;
      logic       k;
      logic       l;
      logic       u;
      bit         f;
      int         p;
   } beat_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] grant;
   logic       busy;
`ifdef ETH_TX_ARBITER_STATS_EN
   logic [31:0] frames0;
   logic [31:0] frames1;
`endif

   int vectors     = 0;
   int miscompares = 0;

   eth_tx_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) s0_if ();
   eth_tx_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) s1_if ();
   eth_tx_arbiter_if #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) m_if ();

   eth_tx_arbiter #(.DATA_WIDTH(DATA_WIDTH), .KEEP_WIDTH(KEEP_WIDTH)) dut (
      .clock   (clock),
      .reset   (reset),
      .s0_axis (s0_if.slave),
      .s1_axis (s1_if.slave),
      .m_axis  (m_if.master),
      .grant   (grant),
      .busy    (busy)
`ifdef ETH_TX_ARBITER_STATS_EN
      ,
      .frames0 (frames0),
      .frames1 (frames1)
`endif
   );

   // Free-running 100 MHz clock.
   always #5 clock = ~clock;

   // Hard stop in case something hangs despite the per-test cycle bounds.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic drive_src(input int p, input logic v, input logic [7:0] d,
                            input logic k, input logic l, input logic u);
      if (p == 0) begin
         s0_if.tvalid = v; s0_if.tdata = d; s0_if.tkeep = k; s0_if.tlast = l; s0_if.tuser = u;
      end else begin
         s1_if.tvalid = v; s1_if.tdata = d; s1_if.tkeep = k; s1_if.tlast = l; s1_if.tuser = u;
      end
   endtask

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset;
      step();
      reset = 1'b1;
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      m_if.tready = 1'b1;
      drive_src(0, 1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
      drive_src(1, 1'b1, 8'hBB, 1'b1, 1'b1, 1'b0);
      step();
      step();
      @(negedge clock);
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 00", grant); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      vectors++; if (m_if.tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_mvalid: got %b expected 0", m_if.tvalid); end
      vectors++; if ({s0_if.tready, s1_if.tready} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_tready: got %b expected 00", {s0_if.tready, s1_if.tready}); end
      vectors++; if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_mdata: got %h expected 0", {m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser}); end
      step();
      reset = 1'b0;
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_single_frame;
      logic [7:0] d [3];
      d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33;
      step();
      m_if.tready = 1'b1;
      drive_src(0, 1'b1, d[0], 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      vectors++; if ({grant, m_if.tvalid} !== 3'b000) begin miscompares++; $display("[TB] FAIL single_decide: got grant=%b mvalid=%b expected 00/0", grant, m_if.tvalid); end
      for (int i = 0; i < 3; i++) begin
         step();
         if (i > 0) drive_src(0, 1'b1, d[i], 1'b1, (i == 2), 1'b0);
         @(negedge clock);
         vectors++; if (grant !== 2'b01) begin miscompares++; $display("[TB] FAIL single_grant: got %b expected 01", grant); end
         vectors++; if ({m_if.tvalid, m_if.tdata, m_if.tlast, s0_if.tready} !== {1'b1, d[i], (i == 2), 1'b1}) begin
            miscompares++; $display("[TB] FAIL single_beat%0d: got v=%b d=%h l=%b r=%b expected v=1 d=%h l=%b r=1", i, m_if.tvalid, m_if.tdata, m_if.tlast, s0_if.tready, d[i], (i == 2));
         end
      end
      step();
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      vectors++; if ({grant, busy, m_if.tvalid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL single_idle: got grant=%b busy=%b mvalid=%b expected 00/0/0", grant, busy, m_if.tvalid); end
   endtask

   // Both ports load frames; reference order is strict alternation starting at
   // port 0 while both have frames pending, then the leftover port alone.
   task automatic run_traffic(input int n0, input int n1, input bit rnd, input string tag);
      beat_t q0[$];
      beat_t q1[$];
      beat_t exp[$];
      beat_t bt;
      beat_t e;
      int    len, i0, i1, idx, cyc, pos0, pos1;
      bit    turn, done, hs0, hs1, v0, v1, expect_idle;
      for (int p = 0; p < 2; p++) begin
         for (int f = 0; f < ((p == 0) ? n0 : n1); f++) begin
            len = rnd ? int'($urandom_range(1, 4)) : 2;
            for (int b = 0; b < len; b++) begin
               bt.d = 8'($urandom_range(0, 255));
               bt.k = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
               bt.l = (b == len - 1);
               bt.u = bt.l ? 1'($urandom_range(0, 1)) : 1'b0;
               bt.f = (b == 0);
               bt.p = p;
               if (p == 0) q0.push_back(bt); else q1.push_back(bt);
            end
         end
      end
      i0 = 0; i1 = 0; turn = 1'b0;
      while (i0 < q0.size() || i1 < q1.size()) begin
         if (i0 < q0.size() && (turn == 1'b0 || i1 >= q1.size())) begin
            do begin exp.push_back(q0[i0]); done = q0[i0].l; i0++; end while (!done);
            turn = 1'b1;
         end else begin
            do begin exp.push_back(q1[i1]); done = q1[i1].l; i1++; end while (!done);
            turn = 1'b0;
         end
      end
      step();
      pos0 = 0; pos1 = 0; v0 = (q0.size() > 0); v1 = (q1.size() > 0);
      if (v0) drive_src(0, 1'b1, q0[0].d, q0[0].k, q0[0].l, q0[0].u);
      if (v1) drive_src(1, 1'b1, q1[0].d, q1[0].k, q1[0].l, q1[0].u);
      m_if.tready = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
      idx = 0; cyc = 0; expect_idle = 1'b0;
      while (idx < exp.size() && cyc < 4000) begin
         @(negedge clock);
         hs0 = s0_if.tvalid & s0_if.tready;
         hs1 = s1_if.tvalid & s1_if.tready;
         if (expect_idle) begin
            expect_idle = 1'b0;
            vectors++; if ({grant, m_if.tvalid} !== 3'b000) begin miscompares++; $display("[TB] FAIL %s_gap: got grant=%b mvalid=%b expected 00/0", tag, grant, m_if.tvalid); end
         end else if (m_if.tvalid) begin
            e = exp[idx];
            vectors++; if (grant !== ((e.p == 1) ? 2'b10 : 2'b01)) begin miscompares++; $display("[TB] FAIL %s_owner: got %b expected port %0d at beat %0d", tag, grant, e.p, idx); end
            vectors++; if (((e.p == 1) ? s0_if.tready : s1_if.tready) !== 1'b0) begin miscompares++; $display("[TB] FAIL %s_loser_ready: got 1 expected 0 at beat %0d", tag, idx); end
            if (m_if.tready) begin
               vectors++; if ({m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser} !== {e.d, e.k, e.l, e.u}) begin
                  miscompares++; $display("[TB] FAIL %s_beat%0d: got %h/%b/%b/%b expected %h/%b/%b/%b", tag, idx, m_if.tdata, m_if.tkeep, m_if.tlast, m_if.tuser, e.d, e.k, e.l, e.u);
               end
               idx++;
               expect_idle = e.l;
            end
         end
         step();
         cyc++;
         if (hs0) pos0++;
         if (hs1) pos1++;
         if (pos0 >= q0.size()) v0 = 1'b0;
         else if (q0[pos0].f) v0 = 1'b1;
         else if (hs0 || !v0) v0 = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
         if (pos1 >= q1.size()) v1 = 1'b0;
         else if (q1[pos1].f) v1 = 1'b1;
         else if (hs1 || !v1) v1 = rnd ? ($urandom_range(0, 99) >= 30) : 1'b1;
         if (pos0 < q0.size()) drive_src(0, v0, q0[pos0].d, q0[pos0].k, q0[pos0].l, q0[pos0].u);
         else drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         if (pos1 < q1.size()) drive_src(1, v1, q1[pos1].d, q1[pos1].k, q1[pos1].l, q1[pos1].u);
         else drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         m_if.tready = rnd ? ($urandom_range(0, 99) < 70) : 1'b1;
      end
      vectors++; if (idx != exp.size()) begin miscompares++; $display("[TB] FAIL %s_complete: got %0d beats expected %0d", tag, idx, exp.size()); end
      @(negedge clock);
      if (expect_idle) begin
         vectors++; if ({grant, busy, m_if.tvalid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL %s_end_idle: got grant=%b busy=%b mvalid=%b expected 00/0/0", tag, grant, busy, m_if.tvalid); end
      end
      m_if.tready = 1'b1;
   endtask

   task automatic test_contention;
      apply_reset();
      run_traffic(4, 4, 1'b0, "contention");
   endtask

   task automatic test_backpressure;
      logic [7:0] b [4];
      int         beat, cyc;
      bit         hs;
      b[0] = 8'hA0; b[1] = 8'hA1; b[2] = 8'hA2; b[3] = 8'hA3;
      step();
      m_if.tready = 1'b1;
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive_src(1, 1'b1, b[0], 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      step();
      drive_src(0, 1'b1, 8'h5A, 1'b1, 1'b1, 1'b0);
      beat = 0; cyc = 0;
      while (beat < 4 && cyc < 20) begin
         @(negedge clock);
         hs = m_if.tready;
         vectors++; if ({grant, s0_if.tready} !== 3'b100) begin miscompares++; $display("[TB] FAIL bp_grant: got grant=%b s0_ready=%b expected 10/0", grant, s0_if.tready); end
         vectors++; if ({m_if.tvalid, m_if.tdata} !== {1'b1, b[beat]}) begin miscompares++; $display("[TB] FAIL bp_beat%0d: got v=%b d=%h expected v=1 d=%h", beat, m_if.tvalid, m_if.tdata, b[beat]); end
         step();
         cyc++;
         if (hs) beat++;
         if (beat < 4) drive_src(1, 1'b1, b[beat], 1'b1, (beat == 3), 1'b0);
         else drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
         m_if.tready = ~m_if.tready;
      end
      vectors++; if (beat != 4) begin miscompares++; $display("[TB] FAIL bp_complete: got %0d beats expected 4", beat); end
      m_if.tready = 1'b1;
      @(negedge clock);
      vectors++; if ({grant, s0_if.tready} !== 3'b000) begin miscompares++; $display("[TB] FAIL bp_idle: got grant=%b s0_ready=%b expected 00/0", grant, s0_if.tready); end
      step();
      @(negedge clock);
      vectors++; if ({grant, m_if.tdata, m_if.tlast, s0_if.tready} !== {2'b01, 8'h5A, 1'b1, 1'b1}) begin
         miscompares++; $display("[TB] FAIL bp_s0_after: got grant=%b d=%h l=%b r=%b expected 01/5a/1/1", grant, m_if.tdata, m_if.tlast, s0_if.tready);
      end
      step();
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL bp_final_idle: got %b expected 00", grant); end
   endtask

   task automatic test_owner_stall;
      logic [7:0] c [3];
      c[0] = 8'hC0; c[1] = 8'hC1; c[2] = 8'hC2;
      step();
      m_if.tready = 1'b1;
      drive_src(0, 1'b1, c[0], 1'b1, 1'b0, 1'b0);
      drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      step();
      drive_src(1, 1'b1, 8'h77, 1'b1, 1'b1, 1'b1);
      @(negedge clock);
      vectors++; if ({grant, m_if.tdata} !== {2'b01, c[0]}) begin miscompares++; $display("[TB] FAIL stall_first: got grant=%b d=%h expected 01/c0", grant, m_if.tdata); end
      step();
      drive_src(0, 1'b0, c[1], 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         if (i > 0) begin
            step();
            s1_if.tvalid = (i % 2 == 0);
         end
         @(negedge clock);
         vectors++; if ({grant, s1_if.tready, m_if.tvalid} !== 4'b0100) begin
            miscompares++; $display("[TB] FAIL stall_hold%0d: got grant=%b s1_ready=%b mvalid=%b expected 01/0/0", i, grant, s1_if.tready, m_if.tvalid);
         end
      end
      for (int i = 1; i < 3; i++) begin
         step();
         s1_if.tvalid = 1'b1;
         drive_src(0, 1'b1, c[i], 1'b1, (i == 2), 1'b0);
         @(negedge clock);
         vectors++; if ({grant, m_if.tvalid, m_if.tdata, m_if.tlast, s1_if.tready} !== {2'b01, 1'b1, c[i], (i == 2), 1'b0}) begin
            miscompares++; $display("[TB] FAIL stall_beat%0d: got grant=%b v=%b d=%h l=%b s1r=%b", i, grant, m_if.tvalid, m_if.tdata, m_if.tlast, s1_if.tready);
         end
      end
      step();
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      vectors++; if ({grant, s1_if.tready} !== 3'b000) begin miscompares++; $display("[TB] FAIL stall_idle: got grant=%b s1_ready=%b expected 00/0", grant, s1_if.tready); end
      step();
      @(negedge clock);
      vectors++; if ({grant, m_if.tdata, m_if.tuser} !== {2'b10, 8'h77, 1'b1}) begin miscompares++; $display("[TB] FAIL stall_s1: got grant=%b d=%h u=%b expected 10/77/1", grant, m_if.tdata, m_if.tuser); end
      step();
      drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midframe;
      step();
      m_if.tready = 1'b1;
      drive_src(0, 1'b1, 8'hD0, 1'b1, 1'b0, 1'b0);
      @(negedge clock);
      step();
      @(negedge clock);
      vectors++; if ({grant, m_if.tdata} !== {2'b01, 8'hD0}) begin miscompares++; $display("[TB] FAIL rstmid_first: got grant=%b d=%h expected 01/d0", grant, m_if.tdata); end
      step();
      drive_src(0, 1'b1, 8'hD1, 1'b1, 1'b0, 1'b0);
      reset = 1'b1;
      @(negedge clock);
      vectors++; if ({grant, m_if.tdata} !== {2'b01, 8'hD1}) begin miscompares++; $display("[TB] FAIL rstmid_sync: got grant=%b d=%h expected 01/d1", grant, m_if.tdata); end
      step();
      reset = 1'b0;
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive_src(1, 1'b1, 8'hE0, 1'b1, 1'b1, 1'b0);
      @(negedge clock);
      vectors++; if ({grant, busy, m_if.tvalid} !== 4'b0000) begin miscompares++; $display("[TB] FAIL rstmid_idle: got grant=%b busy=%b mvalid=%b expected 00/0/0", grant, busy, m_if.tvalid); end
      step();
      @(negedge clock);
      vectors++; if ({grant, m_if.tvalid, m_if.tdata, m_if.tlast} !== {2'b10, 1'b1, 8'hE0, 1'b1}) begin
         miscompares++; $display("[TB] FAIL rstmid_s1: got grant=%b v=%b d=%h l=%b expected 10/1/e0/1", grant, m_if.tvalid, m_if.tdata, m_if.tlast);
      end
      step();
      drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      vectors++; if (grant !== 2'b00) begin miscompares++; $display("[TB] FAIL rstmid_end: got %b expected 00", grant); end
   endtask

   task automatic test_random;
      apply_reset();
      run_traffic(7, 4, 1'b1, "random");
      apply_reset();
      run_traffic(3, 6, 1'b1, "random2");
   endtask

`ifdef ETH_TX_ARBITER_STATS_EN
   task automatic test_stats;
      logic [31:0] f1;
      apply_reset();
      @(negedge clock);
      vectors++; if ({frames0, frames1} !== 64'd0) begin miscompares++; $display("[TB] FAIL stats_reset: got %h/%h expected 0/0", frames0, frames1); end
      step();
      force dut.frames0 = 32'hFFFF_FFFF;
      step();
      release dut.frames0;
      f1 = frames1;
      m_if.tready = 1'b1;
      drive_src(0, 1'b1, 8'h42, 1'b1, 1'b1, 1'b0);
      step();
      step();
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      @(negedge clock);
      vectors++; if (frames0 !== 32'd0) begin miscompares++; $display("[TB] FAIL stats_wrap: got %h expected 00000000", frames0); end
      vectors++; if (frames1 !== f1) begin miscompares++; $display("[TB] FAIL stats_other: got %h expected %h", frames1, f1); end
   endtask
`endif

   // Run every scenario in order, then report.
   initial begin
      m_if.tready = 1'b0;
      drive_src(0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      drive_src(1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_single_frame();
      test_contention();
      test_backpressure();
      test_owner_stall();
      test_reset_midframe();
      test_random();
`ifdef ETH_TX_ARBITER_STATS_EN
      test_stats();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
